forward_pipe_unit: RTL and testbench

Parametrised operand-forwarding and load-use hazard unit for the execute stage. It keeps its own shift register of in-flight register writes for DEPTH post-execute stages, including each result value. For every one of NUM_SRC execute-stage source operands it returns the youngest in-flight value or the register-file value, and it raises a one-cycle stall when a source depends on a load whose data has not yet returned. It replaces the fixed two-input forward muxes and the separate hazard logic.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/forward_match.sv | 33 +++
 rtl/forward_pipe_unit.sv | 86 ++++++++
 tb/tb_forward_pipe_unit.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the execute-stage forwarding logic: the in-flight write
// record and the default data/register widths.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic                  is_load;
        logic                  data_ready;
        logic [DATA_W-1:0]     data;
    } fwd_entry_t;

endpackage

// File: rtl/forward_match.sv
// Per-operand priority match over the in-flight write stages: picks the youngest
// matching entry, otherwise the register-file value.
module forward_match #(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int DEPTH      = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  cpu_pkg::fwd_entry_t [DEPTH-1:0] entries,
    input  logic [REG_ADDR_W-1:0]           src_addr,
    input  logic [DATA_W-1:0]               rf_data,
    output logic [SEL_W-1:0]                sel,
    output logic [DATA_W-1:0]               data,
    output logic                            needs_stall
);

    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise the
        // no-match path would hold its old value and infer a latch.
        sel         = '0;
        data        = rf_data;
        needs_stall = 1'b0;
        // Walk oldest to youngest so the youngest match is the one left standing.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (entries[k].valid && entries[k].addr == src_addr && src_addr != '0) begin
                sel         = SEL_W'(k + 1);
                data        = entries[k].data;
                needs_stall = !entries[k].data_ready;
            end
        end
    end

endmodule

// File: rtl/forward_pipe_unit.sv
// Execute-stage operand forwarding and load-use hazard unit: tracks DEPTH
// post-execute register writes and resolves NUM_SRC operands against them.
module forward_pipe_unit #(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_valid_e,
    input  logic [REG_ADDR_W-1:0]              wr_addr_e,
    input  logic                               wr_is_load_e,
    input  logic [DATA_W-1:0]                  alu_result_e,
    input  logic                               flush_e,
    input  logic [DATA_W-1:0]                  mem_rdata_m,
    input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] src_addr_e,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]     rf_data_e,
    output logic [NUM_SRC-1:0][DATA_W-1:0]     src_data_e,
    output logic [NUM_SRC-1:0][SEL_W-1:0]      fwd_sel_e,
    output logic                               stall_e,
    output logic [31:0]                        stall_count
);

    import cpu_pkg::*;

    fwd_entry_t [DEPTH-1:0] stage_q;
    logic [NUM_SRC-1:0]     needs_stall;
    logic                   accept_e;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        forward_match #(
            .DATA_W     (DATA_W),
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH),
            .SEL_W      (SEL_W)
        ) u_match (
            .entries     (stage_q),
            .src_addr    (src_addr_e[s]),
            .rf_data     (rf_data_e[s]),
            .sel         (fwd_sel_e[s]),
            .data        (src_data_e[s]),
            .needs_stall (needs_stall[s])
        );
    end

    assign stall_e = |needs_stall;

    // A stalled E instruction is re-presented next cycle, so its write is not recorded yet.
    assign accept_e = wr_valid_e && !stall_e && !flush_e && (wr_addr_e != '0);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage
        // shifts from the pre-edge value of its neighbour.
        if (!rst_n) begin
            // NOTE: the tracker is a handful of flops, so whole entries are
            // cleared rather than only the valid bits.
            stage_q <= '0;
        end else begin
            if (accept_e) begin
                stage_q[0] <= '{valid: 1'b1, addr: wr_addr_e, is_load: wr_is_load_e,
                                data_ready: !wr_is_load_e, data: alu_result_e};
            end else begin
                stage_q[0] <= '0;
            end
            stage_q[1] <= stage_q[0];
            if (stage_q[0].is_load) begin
                stage_q[1].data       <= mem_rdata_m;
                stage_q[1].data_ready <= 1'b1;
            end
            for (int i = 2; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall_e && stall_count != '1) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_forward_pipe_unit.sv
// Self-checking bench for forward_pipe_unit: directed scenarios plus random
// traffic against a write-history reference model.
module tb_forward_pipe_unit;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_SRC    = 2;
    localparam int DEPTH      = 2;
    localparam int SEL_W      = $clog2(DEPTH + 1);

    logic                               clk = 1'b0;
    logic                               rst_n;
    logic                               wr_valid_e;
    logic [REG_ADDR_W-1:0]              wr_addr_e;
    logic                               wr_is_load_e;
    logic [DATA_W-1:0]                  alu_result_e;
    logic                               flush_e;
    logic [DATA_W-1:0]                  mem_rdata_m;
    logic [NUM_SRC-1:0][REG_ADDR_W-1:0] src_addr_e;
    logic [NUM_SRC-1:0][DATA_W-1:0]     rf_data_e;
    logic [NUM_SRC-1:0][DATA_W-1:0]     src_data_e;
    logic [NUM_SRC-1:0][SEL_W-1:0]      fwd_sel_e;
    logic                               stall_e;
    logic [31:0]                        stall_count;

    int tests_run = 0;
    int failures  = 0;

    forward_pipe_unit #(
        .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid_e(wr_valid_e), .wr_addr_e(wr_addr_e),
        .wr_is_load_e(wr_is_load_e), .alu_result_e(alu_result_e), .flush_e(flush_e),
        .mem_rdata_m(mem_rdata_m), .src_addr_e(src_addr_e), .rf_data_e(rf_data_e),
        .src_data_e(src_data_e), .fwd_sel_e(fwd_sel_e), .stall_e(stall_e),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Reference model: a history of accepted writes stamped with the cycle they
    // were accepted in; age since acceptance decides visibility and readiness.
    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        bit          is_load;
        logic [31:0] data;
    } wr_rec_t;

    wr_rec_t     hist[$];
    int          now       = 0;
    logic [31:0] exp_count = 0;

    function automatic void model_eval(input int s, output int sel, output logic [31:0] data,
                                       output bit stall);
        int best = -1;
        int idx  = 0;
        sel   = 0;
        data  = rf_data_e[s];
        stall = 1'b0;
        if (src_addr_e[s] != 0) begin
            foreach (hist[i]) begin
                int age = now - hist[i].cyc - 1;
                if (age >= 0 && age < DEPTH && hist[i].addr == src_addr_e[s] &&
                    (best < 0 || age < best)) begin
                    best = age;
                    idx  = i;
                end
            end
        end
        if (best >= 0) begin
            sel = best + 1;
            if (hist[idx].is_load && best == 0) stall = 1'b1;
            else data = hist[idx].data;
        end
    endfunction

    function automatic bit model_stall();
        bit any = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            int          sel;
            logic [31:0] d;
            bit          st;
            model_eval(s, sel, d, st);
            any |= st;
        end
        return any;
    endfunction

    // Advance one clock edge and move the model with the inputs seen at that edge.
    task automatic tick();
        bit st;
        @(posedge clk);
        st = model_stall();
        if (!rst_n) begin
            hist.delete();
            exp_count = 0;
        end else begin
            if (st && exp_count != 32'hFFFF_FFFF) exp_count++;
            foreach (hist[i]) begin
                if (hist[i].cyc == now - 1 && hist[i].is_load) hist[i].data = mem_rdata_m;
            end
            if (!st && !flush_e && wr_valid_e && wr_addr_e != 0)
                hist.push_back('{cyc: now, addr: wr_addr_e, is_load: wr_is_load_e, data: alu_result_e});
        end
        now++;
        while (hist.size() > 0 && now - hist[0].cyc - 1 >= DEPTH) void'(hist.pop_front());
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid_e   = 1'b0;
        wr_addr_e    = '0;
        wr_is_load_e = 1'b0;
        alu_result_e = '0;
        flush_e      = 1'b0;
        mem_rdata_m  = $urandom;
        for (int s = 0; s < NUM_SRC; s++) begin
            src_addr_e[s] = '0;
            rf_data_e[s]  = $urandom;
        end
    endtask

    task automatic set_write(input logic [4:0] a, input bit ld, input logic [31:0] v, input bit fl);
        wr_valid_e   = 1'b1;
        wr_addr_e    = a;
        wr_is_load_e = ld;
        alu_result_e = v;
        flush_e      = fl;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        src_addr_e[0] = 5'd3;
        src_addr_e[1] = 5'd4;
        @(negedge clk);
        for (int s = 0; s < NUM_SRC; s++) begin
            tests_run++;
            if (fwd_sel_e[s] !== '0 || src_data_e[s] !== rf_data_e[s]) begin
                failures++;
                $display("FAIL reset_src%0d: sel=%0d data=%h, expected sel=0 data=%h",
                         s, fwd_sel_e[s], src_data_e[s], rf_data_e[s]);
            end
        end
        tests_run++;
        if (stall_e !== 1'b0 || stall_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_stall: stall=%b count=%0d, expected 0/0", stall_e, stall_count);
        end
        tick();
    endtask

    task automatic test_alu_forward();
        idle_inputs();
        set_write(5'd5, 1'b0, 32'hAAAA_0001, 1'b0);
        tick();
        idle_inputs();
        src_addr_e[0] = 5'd5;
        for (int exp_sel = 1; exp_sel <= DEPTH + 1; exp_sel++) begin
            int          want_sel = (exp_sel <= DEPTH) ? exp_sel : 0;
            logic [31:0] want_dat = (exp_sel <= DEPTH) ? 32'hAAAA_0001 : rf_data_e[0];
            @(negedge clk);
            tests_run++;
            if (fwd_sel_e[0] !== SEL_W'(want_sel) || src_data_e[0] !== want_dat || stall_e !== 1'b0) begin
                failures++;
                $display("FAIL alu_fwd_age%0d: sel=%0d data=%h stall=%b, expected sel=%0d data=%h stall=0",
                         exp_sel, fwd_sel_e[0], src_data_e[0], stall_e, want_sel, want_dat);
            end
            tick();
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        set_write(5'd7, 1'b0, 32'h11, 1'b0);
        tick();
        set_write(5'd7, 1'b0, 32'h22, 1'b0);
        tick();
        idle_inputs();
        src_addr_e[1] = 5'd7;
        @(negedge clk);
        tests_run++;
        if (fwd_sel_e[1] !== SEL_W'(1) || src_data_e[1] !== 32'h22) begin
            failures++;
            $display("FAIL priority: sel=%0d data=%h, expected sel=1 data=00000022",
                     fwd_sel_e[1], src_data_e[1]);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [31:0] c0;
        idle_inputs();
        tick();
        tick();
        c0 = stall_count;
        set_write(5'd9, 1'b1, 32'h1234_5678, 1'b0);
        tick();
        idle_inputs();
        src_addr_e[0] = 5'd9;
        mem_rdata_m   = 32'hDEAD_BEEF;
        @(negedge clk);
        tests_run++;
        if (stall_e !== 1'b1) begin
            failures++;
            $display("FAIL load_use_stall: stall=%b, expected 1", stall_e);
        end
        tick();
        mem_rdata_m = 32'h0BAD_0BAD;
        @(negedge clk);
        tests_run++;
        if (stall_e !== 1'b0 || fwd_sel_e[0] !== SEL_W'(2) || src_data_e[0] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL load_use_fwd: stall=%b sel=%0d data=%h, expected 0/2/deadbeef",
                     stall_e, fwd_sel_e[0], src_data_e[0]);
        end
        tests_run++;
        if (stall_count !== c0 + 32'd1 || stall_count !== 32'd1) begin
            failures++;
            $display("FAIL load_use_count: count=%0d, expected 1", stall_count);
        end
        tick();
    endtask

    task automatic test_zero_and_flush();
        idle_inputs();
        set_write(5'd0, 1'b0, 32'h5555_5555, 1'b0);
        tick();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (fwd_sel_e[0] !== '0 || src_data_e[0] !== rf_data_e[0]) begin
            failures++;
            $display("FAIL r0_no_fwd: sel=%0d data=%h, expected sel=0 data=%h",
                     fwd_sel_e[0], src_data_e[0], rf_data_e[0]);
        end
        set_write(5'd6, 1'b0, 32'h6666_6666, 1'b1);
        tick();
        idle_inputs();
        src_addr_e[0] = 5'd6;
        for (int c = 0; c < DEPTH; c++) begin
            @(negedge clk);
            tests_run++;
            if (fwd_sel_e[0] !== '0 || src_data_e[0] !== rf_data_e[0]) begin
                failures++;
                $display("FAIL flush_no_fwd%0d: sel=%0d data=%h, expected sel=0 data=%h",
                         c, fwd_sel_e[0], src_data_e[0], rf_data_e[0]);
            end
            tick();
        end
    endtask

    task automatic test_reset_during_stall();
        idle_inputs();
        set_write(5'd10, 1'b1, 32'h0, 1'b0);
        tick();
        idle_inputs();
        src_addr_e[0] = 5'd10;
        @(negedge clk);
        tests_run++;
        if (stall_e !== 1'b1) begin
            failures++;
            $display("FAIL rst_stall_pre: stall=%b, expected 1", stall_e);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (stall_e !== 1'b0 || stall_count !== 32'd0 || fwd_sel_e !== '0 || src_data_e !== rf_data_e) begin
            failures++;
            $display("FAIL rst_stall_post: stall=%b count=%0d sel=%h data=%h, expected 0/0/0/%h",
                     stall_e, stall_count, fwd_sel_e, src_data_e, rf_data_e);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_valid_e   = ($urandom_range(0, 3) != 0);
            wr_addr_e    = REG_ADDR_W'($urandom_range(0, 7));
            wr_is_load_e = ($urandom_range(0, 2) == 0);
            alu_result_e = $urandom;
            flush_e      = ($urandom_range(0, 7) == 0);
            mem_rdata_m  = $urandom;
            rst_n        = ($urandom_range(0, 99) != 0);
            for (int s = 0; s < NUM_SRC; s++) begin
                src_addr_e[s] = REG_ADDR_W'($urandom_range(0, 7));
                rf_data_e[s]  = $urandom;
            end
            @(negedge clk);
            tests_run++;
            if (stall_e !== model_stall() || stall_count !== exp_count) begin
                failures++;
                $display("FAIL rand_stall[%0d]: stall=%b count=%0d, expected stall=%b count=%0d",
                         n, stall_e, stall_count, model_stall(), exp_count);
            end
            if (!model_stall()) begin
                for (int s = 0; s < NUM_SRC; s++) begin
                    int          sel;
                    logic [31:0] d;
                    bit          st;
                    model_eval(s, sel, d, st);
                    tests_run++;
                    if (fwd_sel_e[s] !== SEL_W'(sel) || src_data_e[s] !== d) begin
                        failures++;
                        $display("FAIL rand_src%0d[%0d]: sel=%0d data=%h, expected sel=%0d data=%h",
                                 s, n, fwd_sel_e[s], src_data_e[s], sel, d);
                    end
                end
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_alu_forward();
        test_priority();
        test_load_use();
        test_zero_and_flush();
        test_reset_during_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
